// File: rtl/button_pkg.sv
// Shared types and default timing for the button event decoder.
// The FSM encoding is fixed so that the unused code 2'd3 can be recovered explicitly.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } btn_state_e;

    localparam int LONG_TICKS_DFLT   = 1000;
    localparam int REPEAT_TICKS_DFLT = 200;
    localparam int CNT_W_DFLT        = 16;

endpackage

// File: rtl/button_edge_detect.sv
// Registers the debounced level once and derives single-cycle rise/fall strobes
// by comparing the live input against that registered copy.
module button_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic button_level_i,
    output logic rise_o,
    output logic fall_o,
    output logic held_o
);

    logic level_q;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= button_level_i;
        end
    end

    assign rise_o = button_level_i & ~level_q;
    assign fall_o = ~button_level_i & level_q;
    assign held_o = level_q;

endmodule

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle UI events: press, release,
// short press, long press and auto-repeat. All outputs are registered.
module button_event_decoder
    import button_pkg::*;
#(
    parameter int LONG_TICKS   = LONG_TICKS_DFLT,
    parameter int REPEAT_TICKS = REPEAT_TICKS_DFLT,
    parameter bit REPEAT_EN    = 1'b1,
    parameter int CNT_W        = CNT_W_DFLT
) (
    input  logic clk,
    input  logic reset,
    input  logic button_level,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             rise;
    logic             fall;
    btn_state_e       state_q;
    logic [CNT_W-1:0] count_q;
    logic             press_q;
    logic             release_q;
    logic             short_q;
    logic             long_q;
    logic             repeat_q;

    button_edge_detect u_edge (
        .clk            (clk),
        .reset          (reset),
        .button_level_i (button_level),
        .rise_o         (rise),
        .fall_o         (fall),
        .held_o         (held)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            // Pulses default low so each event lasts exactly one cycle.
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (rise) begin
                        // The press edge itself is count 0, so long_press lands
                        // exactly LONG_TICKS cycles after press_pulse.
                        press_q <= 1'b1;
                        state_q <= PRESSED;
                    end
                end

                PRESSED: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        short_q   <= 1'b1;
                        count_q   <= '0;
                        state_q   <= IDLE;
                    end else if (count_q == LONG_LAST) begin
                        long_q  <= 1'b1;
                        count_q <= '0;
                        state_q <= LONG_HELD;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end

                LONG_HELD: begin
                    if (fall) begin
                        release_q <= 1'b1;
                        count_q   <= '0;
                        state_q   <= IDLE;
                    end else if (!REPEAT_EN) begin
                        count_q <= '0;
                    end else if (count_q == REPEAT_LAST) begin
                        repeat_q <= 1'b1;
                        count_q  <= '0;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench: fixed vectors, directed corner sequences and random
// holds, compared against an elapsed-time model of the event rules.
module tb_button_event_decoder;

    localparam int L = 10;
    localparam int R = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button_level = 1'b0;

    logic held_a, press_a, release_a, short_a, long_a, rep_a;
    logic held_b, press_b, release_b, short_b, long_b, rep_b;

    button_event_decoder #(.LONG_TICKS(L), .REPEAT_TICKS(R), .REPEAT_EN(1'b1), .CNT_W(8)) u_dut_en (
        .clk           (clk),
        .reset         (reset),
        .button_level  (button_level),
        .held          (held_a),
        .press_pulse   (press_a),
        .release_pulse (release_a),
        .short_press   (short_a),
        .long_press    (long_a),
        .repeat_pulse  (rep_a)
    );

    button_event_decoder #(.LONG_TICKS(L), .REPEAT_TICKS(R), .REPEAT_EN(1'b0), .CNT_W(8)) u_dut_noen (
        .clk           (clk),
        .reset         (reset),
        .button_level  (button_level),
        .held          (held_b),
        .press_pulse   (press_b),
        .release_pulse (release_b),
        .short_press   (short_b),
        .long_press    (long_b),
        .repeat_pulse  (rep_b)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: remembers only the previous sampled level and when the press began.
    int t = 0;
    bit m_prev = 1'b0;
    bit m_in_press = 1'b0;
    int m_press_t = 0;

    int cnt_press, cnt_long_a, cnt_long_b, cnt_rep_b, cnt_rel, cnt_short;
    int last_press_t, long_off;
    int rep_off[$];

    typedef struct {
        logic       rst;
        logic       lvl;
        logic [5:0] exp; // {held, press, release, short, long, repeat}
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, t, act, exp);
        end
    endtask

    function automatic logic [5:0] get_a();
        return {held_a, press_a, release_a, short_a, long_a, rep_a};
    endfunction

    function automatic logic [5:0] get_b();
        return {held_b, press_b, release_b, short_b, long_b, rep_b};
    endfunction

    task automatic clear_counts();
        cnt_press = 0; cnt_long_a = 0; cnt_long_b = 0; cnt_rep_b = 0;
        cnt_rel = 0; cnt_short = 0; long_off = -1;
        rep_off.delete();
    endtask

    task automatic step(input logic rst, input logic lvl);
        logic [5:0] exp_a;
        logic [5:0] exp_b;
        int h;
        reset = rst;
        button_level = lvl;
        @(posedge clk);
        #1;
        t++;
        exp_a = '0;
        if (rst) begin
            m_prev = 1'b0;
            m_in_press = 1'b0;
        end else begin
            exp_a[5] = lvl;
            if (lvl && !m_prev) begin
                exp_a[4] = 1'b1;
                m_in_press = 1'b1;
                m_press_t = t;
            end else if (!lvl && m_prev && m_in_press) begin
                exp_a[3] = 1'b1;
                exp_a[2] = ((t - m_press_t) <= L);
                m_in_press = 1'b0;
            end else if (lvl && m_in_press) begin
                h = t - m_press_t;
                exp_a[1] = (h == L);
                exp_a[0] = (h > L) && (((h - L) % R) == 0);
            end
            m_prev = lvl;
        end
        exp_b = exp_a;
        exp_b[0] = 1'b0;
        check("outputs_repeat_en", int'(get_a()), int'(exp_a));
        check("outputs_repeat_dis", int'(get_b()), int'(exp_b));
        check("exclusive_events", int'(press_a) + int'(long_a) + int'(rep_a) + 0 > 1 ? 1 : 0, 0);
        check("short_without_release", int'(short_a & ~release_a), 0);

        if (press_a) begin
            cnt_press++;
            last_press_t = t;
        end
        if (long_a) begin
            cnt_long_a++;
            long_off = t - last_press_t;
        end
        if (rep_a) rep_off.push_back(t - last_press_t);
        if (long_b) cnt_long_b++;
        if (rep_b) cnt_rep_b++;
        if (release_a) cnt_rel++;
        if (short_a) cnt_short++;
    endtask

    task automatic hold(input logic rst, input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(rst, lvl);
    endtask

    initial begin
        // Reset, a 5-cycle short press, then a release exactly on the long boundary.
        vecs.push_back('{1'b1, 1'b0, 6'b000000});
        vecs.push_back('{1'b1, 1'b1, 6'b000000});
        vecs.push_back('{1'b0, 1'b1, 6'b110000});
        for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 1'b1, 6'b100000});
        vecs.push_back('{1'b0, 1'b0, 6'b001100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000});
        vecs.push_back('{1'b0, 1'b1, 6'b110000});
        for (int i = 0; i < L - 1; i++) vecs.push_back('{1'b0, 1'b1, 6'b100000});
        vecs.push_back('{1'b0, 1'b0, 6'b001100});
        vecs.push_back('{1'b0, 1'b0, 6'b000000});

        clear_counts();
        last_press_t = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].lvl);
            check($sformatf("vector_%0d", i), int'(get_a()), int'(vecs[i].exp));
        end
        check("boundary_no_long", cnt_long_a, 0);
        check("boundary_short_count", cnt_short, 2);

        // Long press with auto-repeat: 25 cycles from the rise.
        hold(1'b0, 1'b0, 2);
        clear_counts();
        hold(1'b0, 1'b1, 25);
        hold(1'b0, 1'b0, 3);
        check("long_press_count", cnt_long_a, 1);
        check("long_press_offset", long_off, L);
        check("repeat_count", rep_off.size(), 3);
        if (rep_off.size() == 3) begin
            check("repeat_offset_1", rep_off[0], L + R);
            check("repeat_offset_2", rep_off[1], L + 2 * R);
            check("repeat_offset_3", rep_off[2], L + 3 * R);
        end
        check("long_release_count", cnt_rel, 1);
        check("long_release_no_short", cnt_short, 0);

        // Repeat disabled, 30-cycle hold.
        clear_counts();
        hold(1'b0, 1'b1, 30);
        hold(1'b0, 1'b0, 2);
        check("noen_long_count", cnt_long_b, 1);
        check("noen_repeat_count", cnt_rep_b, 0);

        // Reset mid-hold with the button still pressed.
        clear_counts();
        hold(1'b0, 1'b1, 13);
        hold(1'b1, 1'b1, 2);
        check("reset_no_release", cnt_rel, 0);
        check("reset_all_low", int'(get_a()), 0);
        step(1'b0, 1'b1);
        check("reset_repress", int'(press_a), 1);
        hold(1'b0, 1'b1, L);
        check("reset_press_count", cnt_press, 2);
        check("reset_long_count", cnt_long_a, 2);
        check("reset_long_offset", long_off, L);
        hold(1'b0, 1'b0, 2);

        // Back-to-back short presses.
        clear_counts();
        for (int k = 0; k < 3; k++) begin
            hold(1'b0, 1'b1, 2);
            step(1'b0, 1'b0);
        end
        step(1'b0, 1'b0);
        check("b2b_press_count", cnt_press, 3);
        check("b2b_release_count", cnt_rel, 3);
        check("b2b_short_count", cnt_short, 3);

        // Random runs of level, with occasional reset bursts.
        for (int k = 0; k < 300; k++) begin
            logic lvl;
            lvl = logic'($urandom_range(0, 1));
            if ($urandom_range(0, 39) == 0) hold(1'b1, lvl, $urandom_range(1, 2));
            hold(1'b0, lvl, $urandom_range(1, 30));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
